// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam int PC_STEP = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } buf_entry_t;
endpackage

// File: rtl/fetch_buf.sv
// Small FIFO of {instr, pc} entries; head is read straight from storage, zero-latency.
// Synchronous flush empties it; a push and a pop in one cycle leave the count unchanged.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  buf_entry_t                   push_dat,
  input  logic                         pop,
  output buf_entry_t                   head_dat,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  buf_entry_t       mem_q [DEPTH];
  buf_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: count gates its visibility.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
endmodule

// File: rtl/fetch_ctrl.sv
// PC sequencer: fetches one word per cycle into fetch_buf, 1-cycle fetch-to-valid latency.
// Stalls the PC while the buffer is full and not popping; redirects flush; bad PCs fault stickily.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          MEM_BYTES = 128,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_BYTES - PC_STEP);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;

  logic             pc_legal;
  logic             pop;
  logic             can_accept;
  logic             push;
  logic             flush;
  buf_entry_t       push_dat;
  buf_entry_t       head_dat;
  logic [CNT_W-1:0] buf_cnt;
  logic             buf_full;
  logic             buf_empty;

  assign pc_legal   = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_PC);
  assign pop        = if_valid && if_ready;
  // A full buffer still accepts when its head leaves this cycle.
  assign can_accept = !buf_full || pop;
  assign push_dat   = '{instr: imem_rdata, pc: pc_q};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = redirect_target;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (!pc_legal) begin
            state_d    = FAULT;
            fault_pc_d = pc_q;
          end else if (can_accept) begin
            push = 1'b1;
            pc_d = pc_q + ADDR_W'(PC_STEP);
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  fetch_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (buf_cnt),
    .full     (buf_full),
    .empty    (buf_empty)
  );

  a_cnt_bound: assert property (@(posedge clk) disable iff (reset) buf_cnt <= CNT_W'(BUF_DEPTH));

  assign imem_addr = pc_q;
  assign if_valid  = !buf_empty;
  assign if_instr  = head_dat.instr;
  assign if_pc     = head_dat.pc;
  assign fault     = (state_q == FAULT);
  assign fault_pc  = fault_pc_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a combinational word-addressed memory model.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Word at 0 and 8 are fixed; every other word encodes its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a > 32'd124)   return 32'hDEAD_BEEF;
    if (a == 32'd0)    return 32'h0800_0002;
    if (a == 32'd8)    return 32'h0001_1020;
    return 32'hC000_0000 | a;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_ctrl #(
    .MEM_BYTES(128),
    .RESET_PC (32'h0),
    .BUF_DEPTH(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    if_ready       = rdy;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    reset = 1'b1;
    n_checks++; if (if_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    n_checks++; if (fault !== 1'b0)      begin n_fail++; $display("FAIL rst_fault: got %b want 0", fault); end
    n_checks++; if (fault_pc !== 32'h0)  begin n_fail++; $display("FAIL rst_fault_pc: got %h want 0", fault_pc); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_instr;
    do_reset(1'b1);
    step();
    n_checks++; if (if_valid !== 1'b1)          begin n_fail++; $display("FAIL first_valid: got %b want 1", if_valid); end
    n_checks++; if (if_instr !== 32'h0800_0002) begin n_fail++; $display("FAIL first_instr: got %h want 08000002", if_instr); end
    n_checks++; if (if_pc !== 32'h0)            begin n_fail++; $display("FAIL first_pc: got %h want 0", if_pc); end
    n_checks++; if (imem_addr !== 32'h4)        begin n_fail++; $display("FAIL first_addr: got %h want 4", imem_addr); end
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_instr = (k == 2) ? 32'h0001_1020 : (32'hC000_0000 | 32'(4 * k));
      n_checks++; if (if_pc !== 32'(4 * k))           begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", k, if_pc, 32'(4 * k)); end
      n_checks++; if (if_instr !== exp_instr)         begin n_fail++; $display("FAIL stream_instr[%0d]: got %h want %h", k, if_instr, exp_instr); end
      n_checks++; if (imem_addr !== 32'(4 * k + 4))   begin n_fail++; $display("FAIL stream_addr[%0d]: got %h want %h", k, imem_addr, 32'(4 * k + 4)); end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    step();               // push 0
    if_ready = 1'b1;
    step();               // pop 0, push 4
    if_ready = 1'b0;
    step();               // push 8: buffer holds 4, 8
    n_checks++; if (if_pc !== 32'h4) begin n_fail++; $display("FAIL redir_pre_pc: got %h want 4", if_pc); end
    redirect_valid  = 1'b1;
    redirect_target = 32'h8;
    step();
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    n_checks++; if (if_valid !== 1'b0)   begin n_fail++; $display("FAIL redir_bubble: got %b want 0", if_valid); end
    n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL redir_addr: got %h want 8", imem_addr); end
    step();
    n_checks++; if (if_valid !== 1'b1)          begin n_fail++; $display("FAIL redir_valid: got %b want 1", if_valid); end
    n_checks++; if (if_pc !== 32'h8)            begin n_fail++; $display("FAIL redir_pc: got %h want 8", if_pc); end
    n_checks++; if (if_instr !== 32'h0001_1020) begin n_fail++; $display("FAIL redir_instr: got %h want 00011020", if_instr); end
    step();
    n_checks++; if (if_pc !== 32'hC)            begin n_fail++; $display("FAIL redir_next_pc: got %h want c", if_pc); end
    n_checks++; if (if_instr !== 32'hC000_000C) begin n_fail++; $display("FAIL redir_next_instr: got %h want c000000c", if_instr); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_addr;
    do_reset(1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      exp_addr = (k >= 2) ? 32'h8 : 32'h4;
      n_checks++; if (if_valid !== 1'b1)          begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", k, if_valid); end
      n_checks++; if (if_pc !== 32'h0)            begin n_fail++; $display("FAIL bp_pc[%0d]: got %h want 0", k, if_pc); end
      n_checks++; if (if_instr !== 32'h0800_0002) begin n_fail++; $display("FAIL bp_instr[%0d]: got %h want 08000002", k, if_instr); end
      n_checks++; if (imem_addr !== exp_addr)     begin n_fail++; $display("FAIL bp_addr[%0d]: got %h want %h", k, imem_addr, exp_addr); end
    end
    if_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++; if (if_valid !== 1'b1)     begin n_fail++; $display("FAIL bp_drain_valid[%0d]: got %b want 1", k, if_valid); end
      n_checks++; if (if_pc !== 32'(4 * k))  begin n_fail++; $display("FAIL bp_drain_pc[%0d]: got %h want %h", k, if_pc, 32'(4 * k)); end
    end
  endtask

  task automatic test_end_of_mem();
    do_reset(1'b1);
    step();
    redirect_valid  = 1'b1;
    redirect_target = 32'd124;
    step();
    redirect_valid = 1'b0;
    step();
    n_checks++; if (if_valid !== 1'b1)          begin n_fail++; $display("FAIL eom_valid: got %b want 1", if_valid); end
    n_checks++; if (if_pc !== 32'd124)          begin n_fail++; $display("FAIL eom_pc: got %h want 7c", if_pc); end
    n_checks++; if (if_instr !== 32'hC000_007C) begin n_fail++; $display("FAIL eom_instr: got %h want c000007c", if_instr); end
    n_checks++; if (fault !== 1'b0)             begin n_fail++; $display("FAIL eom_nofault: got %b want 0", fault); end
    step();
    n_checks++; if (fault !== 1'b1)         begin n_fail++; $display("FAIL eom_fault: got %b want 1", fault); end
    n_checks++; if (fault_pc !== 32'd128)   begin n_fail++; $display("FAIL eom_fault_pc: got %h want 80", fault_pc); end
    n_checks++; if (if_valid !== 1'b0)      begin n_fail++; $display("FAIL eom_drained: got %b want 0", if_valid); end
    step();
    n_checks++; if (if_valid !== 1'b0)      begin n_fail++; $display("FAIL eom_idle_valid: got %b want 0", if_valid); end
    n_checks++; if (imem_addr !== 32'd128)  begin n_fail++; $display("FAIL eom_pc_hold: got %h want 80", imem_addr); end
    redirect_valid  = 1'b1;
    redirect_target = 32'h0;
    step();
    redirect_valid = 1'b0;
    n_checks++; if (fault !== 1'b0)        begin n_fail++; $display("FAIL eom_clear: got %b want 0", fault); end
    n_checks++; if (fault_pc !== 32'd128)  begin n_fail++; $display("FAIL eom_fpc_kept: got %h want 80", fault_pc); end
    n_checks++; if (imem_addr !== 32'h0)   begin n_fail++; $display("FAIL eom_resume_addr: got %h want 0", imem_addr); end
    step();
    n_checks++; if (if_valid !== 1'b1)     begin n_fail++; $display("FAIL eom_resume_valid: got %b want 1", if_valid); end
    n_checks++; if (if_pc !== 32'h0)       begin n_fail++; $display("FAIL eom_resume_pc: got %h want 0", if_pc); end
  endtask

  task automatic test_misaligned();
    do_reset(1'b1);
    step();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_000A;
    step();
    redirect_valid = 1'b0;
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL mis_pre_fault: got %b want 0", fault); end
    step();
    n_checks++; if (fault !== 1'b1)         begin n_fail++; $display("FAIL mis_fault: got %b want 1", fault); end
    n_checks++; if (fault_pc !== 32'h0A)    begin n_fail++; $display("FAIL mis_fault_pc: got %h want 0a", fault_pc); end
    n_checks++; if (if_valid !== 1'b0)      begin n_fail++; $display("FAIL mis_valid: got %b want 0", if_valid); end
    step();
    n_checks++; if (if_valid !== 1'b0)      begin n_fail++; $display("FAIL mis_valid_hold: got %b want 0", if_valid); end
    n_checks++; if (imem_addr !== 32'h0A)   begin n_fail++; $display("FAIL mis_addr_hold: got %h want 0a", imem_addr); end
  endtask

  task automatic test_reset_in_fault();
    do_reset(1'b0);
    redirect_valid  = 1'b1;
    redirect_target = 32'd120;
    step();
    redirect_valid = 1'b0;
    step();               // push 120
    step();               // push 124, now full
    step();               // PC 128 faults
    n_checks++; if (fault !== 1'b1)     begin n_fail++; $display("FAIL rf_fault: got %b want 1", fault); end
    n_checks++; if (if_pc !== 32'd120)  begin n_fail++; $display("FAIL rf_head: got %h want 78", if_pc); end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    n_checks++; if (if_valid !== 1'b1)  begin n_fail++; $display("FAIL rf_drain_valid: got %b want 1", if_valid); end
    n_checks++; if (if_pc !== 32'd124)  begin n_fail++; $display("FAIL rf_drain_pc: got %h want 7c", if_pc); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (if_valid !== 1'b0)   begin n_fail++; $display("FAIL rf_valid: got %b want 0", if_valid); end
    n_checks++; if (fault !== 1'b0)      begin n_fail++; $display("FAIL rf_fault_clr: got %b want 0", fault); end
    n_checks++; if (fault_pc !== 32'h0)  begin n_fail++; $display("FAIL rf_fault_pc: got %h want 0", fault_pc); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rf_addr: got %h want 0", imem_addr); end
    step();
    n_checks++; if (if_pc !== 32'h0)     begin n_fail++; $display("FAIL rf_restart_pc: got %h want 0", if_pc); end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    step();               // push 0
    step();               // push 4, full
    if_ready        = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'd16;
    step();
    redirect_valid = 1'b0;
    n_checks++; if (if_valid !== 1'b0)    begin n_fail++; $display("FAIL b2b_flush: got %b want 0", if_valid); end
    n_checks++; if (imem_addr !== 32'd16) begin n_fail++; $display("FAIL b2b_addr: got %h want 10", imem_addr); end
    step();
    n_checks++; if (if_pc !== 32'd16)           begin n_fail++; $display("FAIL b2b_pc: got %h want 10", if_pc); end
    n_checks++; if (if_instr !== 32'hC000_0010) begin n_fail++; $display("FAIL b2b_instr: got %h want c0000010", if_instr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_redirect();
    test_backpressure();
    test_end_of_mem();
    test_misaligned();
    test_reset_in_fault();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- PC sequencer and fetch controller for the byte-addressed, big-endian, combinational-read instruction memory (128 bytes, 32-bit words).
- Drives the fetch address, captures returned words with their PC into a small instruction buffer, and presents them to decode over a valid/ready handshake.
- Accepts jump/branch redirects from execute, which flush the buffer.
- Detects misaligned or out-of-range fetch addresses and enters a sticky fault state.

Parameters:
- MEM_BYTES, 128, instruction memory size in bytes; legal fetch PC satisfies PC <= MEM_BYTES-4.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- BUF_DEPTH, 2, instruction buffer entries (power of 2, >=2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  fetch address to instruction memory (the PC register).
- imem_rdata  in  32  instruction word returned combinationally for imem_addr.
- redirect_valid  in  1  one-cycle pulse: load PC from redirect_target and flush.
- redirect_target  in  32  jump/branch target byte address.
- if_valid  out  1  buffer head holds a valid instruction.
- if_ready  in  1  decode accepts the head this cycle.
- if_instr  out  32  head instruction word.
- if_pc  out  32  PC of the head instruction.
- fault  out  1  sticky fetch fault.
- fault_pc  out  32  PC that caused the fault.

Behaviour:
- Clock and reset are decided: one clock, clk; reset is synchronous and active-high.
- Reset values: PC=RESET_PC, buffer empty, if_valid=0, fault=0, fault_pc=0, state=RUN. Reset mid-operation discards all buffered entries.
- State RUN, PC legal, buffer can accept: at the edge, push {imem_rdata, PC} and set PC<=PC+4. The PC is legal when PC[1:0]==0 and PC<=MEM_BYTES-4.
- Buffer can accept when count<BUF_DEPTH, or when count==BUF_DEPTH and a handshake (if_valid&&if_ready) pops this cycle. This sustains 1 instruction/cycle with no full bubble.
- Latency: the first edge with reset=0 fetches RESET_PC. if_valid=1 immediately after that edge; the fetch-to-if_valid delay is 1 cycle.
- Pop: if_valid&&if_ready removes the head at the edge. if_instr and if_pc come from registered storage and are stable while if_valid&&!if_ready.
- RUN with PC illegal: at the edge, no push; state<=FAULT, fault<=1, fault_pc<=PC, PC holds.
- In FAULT, already-buffered entries still drain normally, and no fetches occur.
- Redirect has top priority in any state. At the edge, the buffer is cleared, PC<=redirect_target, no push that cycle, state<=RUN and fault<=0. fault_pc is retained.
  - if_valid is 0 for exactly one cycle after the redirect edge.
  - The target instruction appears 1 cycle later, provided the target is legal.
  - An illegal target faults on the following edge.
- A redirect coincident with a handshake: the pop is honoured (decode consumed the head), then the flush applies.
- PC+4 is a 32-bit add with wrap. PC=MEM_BYTES-4 is legal; the following PC=MEM_BYTES faults.
- Simultaneous push and pop at any count keeps count unchanged.
- Buffer pointers wrap modulo BUF_DEPTH.

Decomposition:
- Package fetch_pkg: state enum {RUN, FAULT}, INSTR_W=32, ADDR_W=32, PC_STEP=4.
- Sub-module fetch_buf: BUF_DEPTH-entry FIFO of {instr, pc} with push, pop, synchronous flush, count/full/empty.
- fetch_ctrl holds the PC register, legality check, state machine and push/flush control.

Test Plan:
- Reset, memory preloaded with 0x08000002 at 0 and 0x00011020 at 8, if_ready=1: first edge gives if_valid=1, if_instr=0x08000002, if_pc=0. The next cycle gives if_pc=4, and imem_addr increments by 4 each cycle.
- Redirect to 8 while the buffer holds PCs 4 and 8: the buffer is flushed and if_valid=0 for one cycle, then if_instr=0x00011020 with if_pc=8, then if_pc=12.
- if_ready=0 for 5 cycles from reset: count saturates at 2, imem_addr holds at 8, and if_pc stays 0 with stable if_instr. After if_ready=1, the sequence is if_pc=0, 4, 8, … with no gaps or duplicates.
- Redirect to 124: 124 is delivered, then fault=1 with fault_pc=128, no further if_valid after drain. A subsequent redirect to 0 gives fault=0 and fetch resumes at 0.
- Redirect to 0x0000000A (misaligned): fault=1, fault_pc=0x0A on the next edge, if_valid stays 0.
- Reset asserted with buffer full and in FAULT: the next cycle gives if_valid=0, fault=0, imem_addr=RESET_PC. The bench also checks that a redirect in the same cycle as a handshake drops the second entry.
